// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a persistent NZVC flag register.
// Single-cycle ops (ADD/SUB/ADC/SBC/AND/OR/XOR/NOT) complete one cycle after start.
// Shifts (SHL/SHR/SAR) iterate one bit per cycle under a start/busy/done handshake.
// Optional feature macro: ALU_SEQ_MUL_EN enables op 11 MUL, an iterative shift-add
// multiply. Without the macro, op 11 is illegal and no multiplier state exists.
module alu_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       nzvc_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CntW = SHAMT_W + 1;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAdc = 4'd2;
    localparam logic [3:0] OpSbc = 4'd3;
    localparam logic [3:0] OpAnd = 4'd4;
    localparam logic [3:0] OpOr  = 4'd5;
    localparam logic [3:0] OpXor = 4'd6;
    localparam logic [3:0] OpNot = 4'd7;
    localparam logic [3:0] OpShl = 4'd8;
    localparam logic [3:0] OpShr = 4'd9;
    localparam logic [3:0] OpSar = 4'd10;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OpMul = 4'd11;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShift
`ifdef ALU_SEQ_MUL_EN
        ,
        StMul
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         nzvc_q, nzvc_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   work_q, work_d;     // shift operand, or multiplier under MUL
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         sop_q, sop_d;       // latched shift kind: op[1:0] of SHL/SHR/SAR
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_nx;
`endif

    logic             cin;
    logic [WIDTH:0]   ext;
    logic             v_w;
    logic [WIDTH-1:0] shifted;
    logic             sh_out;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic v,
                                            input logic c);
        return {r[WIDTH-1], (r == '0), v, c};
    endfunction

    // Next-state: op decode and launch in IDLE/EXEC, iteration in SHIFT/MUL.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        nzvc_d   = nzvc_q;
        done_d   = 1'b0;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        acc_nx   = acc_q;
`endif
        cin      = ((op_i == OpAdc) || (op_i == OpSbc)) && nzvc_q[0];
        ext      = '0;
        v_w      = 1'b0;
        shifted  = work_q;
        sh_out   = 1'b0;

        unique case (state_q)
            // EXEC is the done cycle of a single-cycle op; it accepts start like IDLE
            // so back-to-back ops need no bubble.
            StIdle, StExec: begin
                state_d = StIdle;
                if (start_i) begin
                    state_d = StExec;
                    done_d  = 1'b1;
                    case (op_i)
                        OpAdd, OpAdc: begin
                            ext = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
                            v_w = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                  (ext[WIDTH-1] != a_i[WIDTH-1]);
                            result_d = ext[WIDTH-1:0];
                            nzvc_d   = mk_flags(ext[WIDTH-1:0], v_w, ext[WIDTH]);
                        end
                        OpSub, OpSbc: begin
                            // Top bit of the WIDTH+1 difference is the borrow.
                            ext = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};
                            v_w = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                  (ext[WIDTH-1] != a_i[WIDTH-1]);
                            result_d = ext[WIDTH-1:0];
                            nzvc_d   = mk_flags(ext[WIDTH-1:0], v_w, ext[WIDTH]);
                        end
                        OpAnd: begin
                            result_d = a_i & b_i;
                            nzvc_d   = mk_flags(a_i & b_i, 1'b0, 1'b0);
                        end
                        OpOr: begin
                            result_d = a_i | b_i;
                            nzvc_d   = mk_flags(a_i | b_i, 1'b0, 1'b0);
                        end
                        OpXor: begin
                            result_d = a_i ^ b_i;
                            nzvc_d   = mk_flags(a_i ^ b_i, 1'b0, 1'b0);
                        end
                        OpNot: begin
                            result_d = ~a_i;
                            nzvc_d   = mk_flags(~a_i, 1'b0, 1'b0);
                        end
                        OpShl, OpShr, OpSar: begin
                            if (b_i[SHAMT_W-1:0] == '0) begin
                                // Zero amount finishes like a single-cycle op.
                                result_d = a_i;
                                nzvc_d   = mk_flags(a_i, 1'b0, 1'b0);
                            end else begin
                                state_d = StShift;
                                done_d  = 1'b0;
                                work_d  = a_i;
                                cnt_d   = {1'b0, b_i[SHAMT_W-1:0]};
                                sop_d   = op_i[1:0];
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OpMul: begin
                            state_d = StMul;
                            done_d  = 1'b0;
                            work_d  = b_i;
                            mcand_d = {{WIDTH{1'b0}}, a_i};
                            acc_d   = '0;
                            cnt_d   = CntW'(WIDTH);
                        end
`endif
                        // Illegal: result and flags hold, done still pulses.
                        default: ;
                    endcase
                end
            end
            StShift: begin
                case (sop_q)
                    2'd0: begin
                        shifted = {work_q[WIDTH-2:0], 1'b0};
                        sh_out  = work_q[WIDTH-1];
                    end
                    2'd1: begin
                        shifted = {1'b0, work_q[WIDTH-1:1]};
                        sh_out  = work_q[0];
                    end
                    default: begin
                        shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                        sh_out  = work_q[0];
                    end
                endcase
                if (cnt_q == CntW'(1)) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    result_d = shifted;
                    nzvc_d   = mk_flags(shifted, 1'b0, sh_out);
                end else begin
                    work_d = shifted;
                    cnt_d  = cnt_q - CntW'(1);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
                acc_nx = work_q[0] ? (acc_q + mcand_q) : acc_q;
                if (cnt_q == CntW'(1)) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    result_d = acc_nx[WIDTH-1:0];
                    nzvc_d   = mk_flags(acc_nx[WIDTH-1:0], |acc_nx[2*WIDTH-1:WIDTH],
                                        |acc_nx[2*WIDTH-1:WIDTH]);
                end else begin
                    acc_d   = acc_nx;
                    mcand_d = mcand_q << 1;
                    work_d  = work_q >> 1;
                    cnt_d   = cnt_q - CntW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            nzvc_q   <= 4'b0000;
            done_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            sop_q    <= 2'd0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            nzvc_q   <= nzvc_d;
            done_q   <= done_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
`endif
        end
    end

    // Outputs come straight from registers; busy reflects the iterative states.
    always_comb begin
        result_o = result_q;
        nzvc_o   = nzvc_q;
        done_o   = done_q;
`ifdef ALU_SEQ_MUL_EN
        busy_o   = (state_q == StShift) || (state_q == StMul);
`else
        busy_o   = (state_q == StShift);
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven checks of alu_seq (WIDTH=8) with a result scoreboard,
// plus hand-written sequences for ignored start, back-to-back, illegal op, MUL and
// reset mid-shift.
module tb_alu_seq;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8, OP_SHR = 4'd9, OP_SAR = 4'd10, OP_MUL = 4'd11;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic [3:0] nzvc;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] nzvc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] nzvc;
        int         lat;
        string      name;
    } vec_t;
    vec_t vecs[17];

    alu_seq #(.WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (result),
        .nzvc_o   (nzvc),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive a start cycle (caller is at a negedge) and record the expected outcome.
    task automatic issue(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] r, input logic [3:0] f);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        e.res  = r;
        e.nzvc = f;
        sb_q.push_back(e);
    endtask

    // Wait for done after a start cycle; scramble inputs afterwards, optionally pulse
    // a competing start at cycle inj, then check latency, busy and the scoreboard.
    task automatic wait_done(input int lat, input int inj, input string name);
        int   n;
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        n = 1;
        while (!done && n < 64) begin
            check({name, " busy"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
            n++;
            start = (n == inj);
            if (n == inj) begin
                op = OP_ADD;
                a  = 8'h11;
                b  = 8'h22;
            end
        end
        start = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles, expected %0d", name, n, lat);
        end else begin
            check({name, " latency"}, n, lat);
            check({name, " busy at done"}, {31'b0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard: done with no expected entry", name);
            end else begin
                e = sb_q.pop_front();
                check({name, " result"}, {24'b0, result}, {24'b0, e.res});
                check({name, " nzvc"}, {28'b0, nzvc}, {28'b0, e.nzvc});
            end
        end
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        issue(v.op, v.a, v.b, v.res, v.nzvc);
        wait_done(v.lat, 0, v.name);
    endtask

    initial begin
        int   saw_done;
        vec_t v;

        vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1010, 1, "add_ovf"};
        vecs[1]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001, 1, "sub_borrow"};
        vecs[2]  = '{OP_SBC, 8'h05, 8'h02, 8'h02, 4'b0000, 1, "sbc_cin"};
        vecs[3]  = '{OP_SHL, 8'h81, 8'h03, 8'h08, 4'b0000, 4, "shl3"};
        vecs[4]  = '{OP_SAR, 8'h80, 8'h07, 8'hFF, 4'b1000, 8, "sar7"};
        vecs[5]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0101, 1, "add_carry"};
        vecs[6]  = '{OP_ADC, 8'h10, 8'h20, 8'h31, 4'b0000, 1, "adc_cin"};
        vecs[7]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0010, 1, "sub_ovf"};
        vecs[8]  = '{OP_OR,  8'h0C, 8'h30, 8'h3C, 4'b0000, 1, "or"};
        vecs[9]  = '{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 4'b1000, 1, "xor"};
        vecs[10] = '{OP_NOT, 8'h55, 8'h00, 8'hAA, 4'b1000, 1, "not"};
        vecs[11] = '{OP_SHL, 8'hA5, 8'h00, 8'hA5, 4'b1000, 1, "shl0"};
        vecs[12] = '{OP_SHR, 8'h01, 8'h01, 8'h00, 4'b0101, 2, "shr1"};
        vecs[13] = '{OP_ADC, 8'h7F, 8'h00, 8'h80, 4'b1010, 1, "adc_ovf"};
        vecs[14] = '{OP_SBC, 8'h00, 8'h00, 8'h00, 4'b0100, 1, "sbc_zero"};
        vecs[15] = '{OP_SAR, 8'h7F, 8'h09, 8'h3F, 4'b0001, 2, "sar_amt_mask"};
        vecs[16] = '{OP_SBC, 8'h10, 8'h05, 8'h0A, 4'b0000, 1, "sbc_cin2"};

        start = 1'b0;
        op    = 4'd0;
        a     = 8'd0;
        b     = 8'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset result", {24'b0, result}, 32'h0);
        check("reset nzvc", {28'b0, nzvc}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Start pulsed mid-shift is ignored; then a start on the done cycle is taken.
        @(negedge clk);
        issue(OP_SHR, 8'hF0, 8'h04, 8'h0F, 4'b0000);
        wait_done(5, 2, "shr4_ignore");
        issue(OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0100);
        wait_done(1, 0, "and_b2b");

        // Illegal op leaves result/flags as set by the preceding SUB.
        v = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001, 1, "sub_pre"};
        run_op(v);
        v = '{4'd13, 8'h12, 8'h34, 8'hFF, 4'b1001, 1, "illegal13"};
        run_op(v);
        @(negedge clk);
        check("done single pulse", {31'b0, done}, 32'h0);

`ifdef ALU_SEQ_MUL_EN
        v = '{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0111, 9, "mul"};
`else
        v = '{OP_MUL, 8'h10, 8'h10, 8'hFF, 4'b1001, 1, "mul_illegal"};
`endif
        run_op(v);

        // Reset in the second cycle of a 5-bit SHL aborts it without done.
        @(negedge clk);
        start = 1'b1;
        op    = OP_SHL;
        a     = 8'h03;
        b     = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid-shift busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort result", {24'b0, result}, 32'h0);
        check("abort nzvc", {28'b0, nzvc}, 32'h0);
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("no done after abort", saw_done, 0);

        v = '{OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1, "add_after_reset"};
        run_op(v);

        check("scoreboard drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 8-bit combinational ALU: WIDTH-bit operands, 4-bit opcode, persistent NZVC flag register.
- Adds carry-chained ops (ADC/SBC) and multi-cycle iterative shifts under a start/busy/done handshake.
- Sits between the register file and the writeback mux of the datapath.
- Single-cycle ops finish in 1 cycle; shifts take one cycle per bit position.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), width of shift amount taken from B[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  4  opcode, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- result  out  WIDTH  registered result, held until the next completion.
- nzvc  out  4  flag register {N,Z,V,C}, held until the next completion.
- busy  out  1  high while a multi-cycle op is in progress.
- done  out  1  one-cycle pulse when result/nzvc update.

Behaviour:
- Reset (async, rst_n=0): result=0, nzvc=4'b0000, busy=0, done=0, FSM→IDLE, internal shift count=0. Reset mid-shift aborts the op with no done pulse.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 ADC: A+B+C_flag.
  - 3 SBC: A−B−C_flag.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~A.
  - 8 SHL: logical left.
  - 9 SHR: logical right.
  - 10 SAR: arithmetic right.
  - 11 MUL: only with the optional feature.
  - 12-15: illegal.
- C_flag for ADC/SBC is nzvc[0] as held at the start cycle.
- Arithmetic is computed WIDTH+1 wide:
  - C (add) = carry out.
  - C (sub) = borrow, i.e. 1 when A < B+Cin unsigned.
  - V (add) = operands share a sign and the result sign differs.
  - V (sub) = operand signs differ and the result sign differs from A.
- Logic ops: V=0, C=0.
- All ops: N=result[WIDTH-1]; Z=(result==0).
- FSM states:
  - IDLE → EXEC when start=1 and op is single-cycle (0-7) or illegal.
  - EXEC → IDLE next cycle. Result and flags are registered at the end of the start cycle. done=1 in the following cycle, so latency is 1 cycle.
  - IDLE → SHIFT when start=1 and op is 8-10. The shift amount is latched from b[SHAMT_W-1:0] and A is loaded into the working register.
  - SHIFT: one bit position per cycle; C receives each bit shifted out, so the final C is the last bit out.
  - SHIFT → IDLE when the count reaches 0. Result and flags update on that edge; done pulses the next cycle.
- Shift timing and flags:
  - Latency = amount+1 cycles; amount 0 completes like a single-cycle op with C=0 and result=A.
  - Shifts: V=0.
- busy is 1 from the cycle after start through the completion edge of any multi-cycle op. It stays 0 for single-cycle ops.
- start while busy=1 is ignored: no sampling, no effect on the current op.
- start asserted in the same cycle as done is accepted; back-to-back ops are allowed.
- Illegal op: result and nzvc unchanged; done still pulses after 1 cycle so the requester never hangs.
- Inputs a, b and op may change freely after the start cycle; only latched copies are used.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 11 MUL is an unsigned shift-add multiply.
  - State MUL: WIDTH iterations, one per cycle; latency WIDTH+1 cycles; busy held throughout.
  - result = low WIDTH bits of A*B.
  - C = 1 if the high WIDTH bits are non-zero; V = C.
  - N and Z follow the low-half result.
- Undefined: op 11 is treated as illegal, and no multiplier registers or MUL state are synthesised.

Test Plan (WIDTH=8):
- Reset then ADD a=8'h7F, b=8'h01 → one cycle later done=1, result=8'h80, nzvc=4'b1010.
- SUB a=8'h00, b=8'h01 → result=8'hFF, nzvc=4'b1001. Then SBC a=8'h05, b=8'h02 → result=8'h02 (borrow consumed), nzvc=4'b0000.
- SHL a=8'h81, b=3 → busy high for 3 cycles, done on cycle 4, result=8'h08, C=0. Then SAR a=8'h80, b=7 → result=8'hFF, nzvc=4'b1000.
- During the SHR a=8'hF0, b=4 shift, pulse start with op=ADD → ignored; result=8'h0F, C=0. Then start on the done cycle with AND a=8'hF0, b=8'h0F → accepted, result=8'h00, nzvc=4'b0100.
- Drop rst_n mid-SHL (b=5, cycle 2) → result, nzvc, busy and done are 0 immediately; no done after release. Illegal op 13 → done pulses, flags unchanged.
- With ALU_SEQ_MUL_EN, MUL a=8'h10, b=8'h10 → done after 9 cycles, result=8'h00, nzvc=4'b0111. Without the macro, the same op → illegal behaviour.
